// File: rtl/dm_pkg.sv
// dm_pkg: shared FSM state, Funct3 access codes and lane/extension helpers for dm_ctrl.
package dm_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} dm_state_e;
    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;
    // Halfword lanes ignore Addr[0], word lanes ignore Addr[1:0]: alignment is forced here.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        return (f3 == DM_B || f3 == DM_BU) ? 4'b0001 << a :
               (f3 == DM_H || f3 == DM_HU) ? (a[1] ? 4'b1100 : 4'b0011) :
               (f3 == DM_W) ? 4'b1111 : 4'b0000;
    endfunction
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        return (f3[1:0] == 2'b00) ? {4{d[7:0]}} : (f3[1:0] == 2'b01) ? {2{d[15:0]}} : d;
    endfunction
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w, input logic [1:0] a);
        logic [7:0] b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        return (f3 == DM_B)  ? {{24{b[7]}}, b} :
               (f3 == DM_BU) ? {24'b0, b} :
               (f3 == DM_H)  ? {{16{h[15]}}, h} :
               (f3 == DM_HU) ? {16'b0, h} :
               (f3 == DM_W)  ? w : 32'b0;
    endfunction
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3 == DM_H || f3 == DM_HU) && a[0]) || (f3 == DM_W && a != 2'b00);
    endfunction
endpackage

// File: rtl/dm_if.sv
// dm_if: MEM-stage request / data-memory response bundle.
interface dm_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        Stall;
    logic        Done;
    logic        MisAlign;
    modport master (output MemRead, MemWrite, Funct3, Addr, WData, input RData, Stall, Done, MisAlign);
    modport slave  (input MemRead, MemWrite, Funct3, Addr, WData, output RData, Stall, Done, MisAlign);
endinterface

// File: rtl/dm_ram.sv
// dm_ram: single-port word RAM with per-byte write enables and registered read.
module dm_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       re_i,
    input  logic [3:0]                 we_i,
    input  logic [$clog2(DEPTH)-1:0]   addr_i,
    input  logic [31:0]                wdata_i,
    output logic [31:0]                rdata_o
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        if (re_i) rdata_q <= mem[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: data-memory responder with fixed access latency and pipeline stall.
// Define DM_MISALIGN_TRAP_EN to flag (and suppress) misaligned accesses instead of forcing alignment.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rstn,
    dm_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    dm_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q, rdata_q, rd;
    logic [2:0]    f3_q;
    logic          wr_q, done_q, mis_q, req, commit, bad;
    logic [3:0]    be;
    assign req    = bus.MemRead | bus.MemWrite;
    assign commit = state_q == BUSY && cnt_q == '0;
`ifdef DM_MISALIGN_TRAP_EN
    assign bad = misaligned(f3_q, addr_q[1:0]);
`else
    assign bad = 1'b0;
`endif
    // Only sb/sh/sw store; the unsigned load codes write nothing.
    assign be = (commit && wr_q && !bad && !f3_q[2]) ? lane_be(f3_q, addr_q[1:0]) : 4'b0000;
    // The word is read at acceptance; no other write can intervene before commit.
    dm_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .re_i    (state_q == IDLE && req),
        .we_i    (be),
        .addr_i  (state_q == IDLE ? bus.Addr[AW+1:2] : addr_q[AW+1:2]),
        .wdata_i (store_data(f3_q, wdata_q)),
        .rdata_o (rd)
    );
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            case (state_q)
                IDLE: if (req) begin
                    state_q <= BUSY;
                    addr_q  <= bus.Addr[AW+1:0];
                    wdata_q <= bus.WData;
                    f3_q    <= bus.Funct3;
                    wr_q    <= bus.MemWrite;
                    cnt_q   <= CW'(LATENCY - 1);
                end
                BUSY: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                else begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    mis_q   <= bad;
                    if (bad) rdata_q <= '0;
                    else if (!wr_q) rdata_q <= load_ext(f3_q, rd, addr_q[1:0]);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.Stall    = state_q == BUSY || (state_q == IDLE && req);
    assign bus.Done     = done_q;
    assign bus.RData    = rdata_q;
    assign bus.MisAlign = mis_q;
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed scoreboard bench for dm_ctrl (DEPTH=1024, LATENCY=2).
module tb_dm_ctrl;
    localparam int LAT = 2;
    typedef struct packed { logic [31:0] rdata; logic mis; } exp_t;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    dm_if bus ();
    dm_ctrl #(.DEPTH(1024), .LATENCY(LAT)) u_dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;
    exp_t q[$];
    int passed = 0, total = 0, run = 0;
    logic [31:0] last_rd = '0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    always @(negedge clk) begin
        if (!rstn) run = 0;
        else begin
            if (bus.Stall) run++;
            if (bus.Done) begin
                if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", bus.RData, e.rdata);
                    chk("misalign", {31'b0, bus.MisAlign}, {31'b0, e.mis});
                    chk("stall_cycles", run, LAT + 1);
                    chk("stall_low_on_done", {31'b0, bus.Stall}, 32'd0);
                end
                run = 0;
            end
        end
    end
    task automatic acc(input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input bit mis);
        bit seen;
        exp_t e;
        e.mis   = mis;
        e.rdata = mis ? 32'h0 : (wr ? last_rd : exp);
        last_rd = e.rdata;
        q.push_back(e);
        bus.MemRead = !wr; bus.MemWrite = wr; bus.Funct3 = f3; bus.Addr = a; bus.WData = wd;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.Done;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    endtask
    initial begin
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Funct3 = '0; bus.Addr = '0; bus.WData = '0;
        repeat (3) @(posedge clk);
        #1 chk("rst_stall", {31'b0, bus.Stall}, 32'd0);
        chk("rst_done", {31'b0, bus.Done}, 32'd0);
        chk("rst_rdata", bus.RData, 32'd0);
        chk("rst_misalign", {31'b0, bus.MisAlign}, 32'd0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        acc(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0);
        acc(0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0);
        acc(1, 3'b010, 32'h20, 32'h11223344, 0, 0);
        acc(1, 3'b000, 32'h21, 32'h00000080, 0, 0);
        acc(0, 3'b000, 32'h21, 0, 32'hFFFFFF80, 0);
        acc(0, 3'b100, 32'h21, 0, 32'h00000080, 0);
        acc(0, 3'b010, 32'h20, 0, 32'h11228044, 0);
        acc(0, 3'b000, 32'h23, 0, 32'h00000011, 0);
        acc(1, 3'b001, 32'h22, 32'h12348001, 0, 0);
        acc(0, 3'b001, 32'h22, 0, 32'hFFFF8001, 0);
        acc(0, 3'b101, 32'h22, 0, 32'h00008001, 0);
        acc(0, 3'b010, 32'h20, 0, 32'h80018044, 0);
        acc(1, 3'b010, 32'h1000, 32'hCAFEF00D, 0, 0);
        acc(0, 3'b010, 32'h0, 0, 32'hCAFEF00D, 0);
        acc(1, 3'b011, 32'h20, 32'hFFFFFFFF, 0, 0);
        acc(0, 3'b010, 32'h20, 0, 32'h80018044, 0);
        acc(0, 3'b011, 32'h20, 0, 32'h00000000, 0);
        acc(1, 3'b010, 32'h30, 32'h11111111, 0, 0);
        bus.MemWrite = 1'b1; bus.MemRead = 1'b0; bus.Funct3 = 3'b010; bus.Addr = 32'h30; bus.WData = 32'h22222222;
        @(posedge clk); #2;
        rstn = 1'b0; bus.MemWrite = 1'b0;
        #1 chk("abort_stall", {31'b0, bus.Stall}, 32'd0);
        chk("abort_done", {31'b0, bus.Done}, 32'd0);
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        acc(0, 3'b010, 32'h30, 0, 32'h11111111, 0);
`ifdef DM_MISALIGN_TRAP_EN
        acc(0, 3'b010, 32'h13, 0, 0, 1);
        acc(1, 3'b010, 32'h12, 32'h55555555, 0, 1);
        acc(0, 3'b001, 32'h11, 0, 0, 1);
        acc(0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0);
`else
        acc(0, 3'b010, 32'h13, 0, 32'hDEADBEEF, 0);
        acc(0, 3'b001, 32'h13, 0, 32'hFFFFDEAD, 0);
`endif
        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", passed, total);
        $fatal(1);
    end
endmodule
